// File: rtl/mem_dma_pkg.sv
// Shared types for the memory-to-memory copy engine.
// Holds the controller state encoding, the copy direction and the
// memory_map MMIO window layout used by benches that target it.
package mem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef enum logic {
    FWD = 1'b0,
    BWD = 1'b1
  } dir_t;

  // MMIO window of memory_map: 14 registers spaced 0x100 apart from 0x000,
  // with an unmapped hole at 0xE00. The copy engine treats it as plain memory.
  localparam logic [15:0] MMIO_BASE     = 16'h0000;
  localparam logic [15:0] MMIO_STRIDE   = 16'h0100;
  localparam int unsigned MMIO_NUM_REGS = 14;
  localparam logic [15:0] MMIO_HOLE     = 16'h0E00;

  function automatic logic [15:0] mmio_reg_addr(input logic [3:0] idx);
    logic [15:0] off;
    off = {8'h00, 4'h0, idx} << 8;
    return MMIO_BASE + off;
  endfunction

endpackage

// File: rtl/mem_dma_addr_gen.sv
// Address sequencer for one side (read or write) of the copy engine.
// Loads a start address, direction and element count, then steps the
// address by +/-1 per enable (modulo 2^ADDR_WIDTH) and flags the final
// element so the controller knows when the side is exhausted.
module mem_dma_addr_gen
  import mem_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] start,
  input  dir_t                  dir,
  input  logic [ADDR_WIDTH-1:0] count,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] remain;
  dir_t                  dir_q;

  // Address/remaining-count register; holds on the last element.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      remain <= '0;
      dir_q  <= FWD;
    end else if (load) begin
      addr   <= start;
      remain <= count - ONE;
      dir_q  <= dir;
    end else if (step && !last) begin
      addr   <= (dir_q == BWD) ? (addr - ONE) : (addr + ONE);
      remain <= remain - ONE;
    end
  end

  // Last element is the one presented when no further steps remain.
  always_comb begin
    last = (remain == '0);
  end

endmodule

// File: rtl/mem_dma_copy.sv
// Block copy engine: reads memory_map port B, writes port A, one word per
// cycle after a three-cycle fill (address -> memory read -> data register).
// Direction is chosen at accept time so overlapping regions copy with
// memmove semantics. Optional feature: define MEM_DMA_CSUM_EN to add a
// running modulo-2^DATA_WIDTH checksum output of all written words.
module mem_dma_copy
  import mem_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic                  mem_we_b,
  output logic [DATA_WIDTH-1:0] mem_data_b,
  input  logic [DATA_WIDTH-1:0] mem_q_b,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [DATA_WIDTH-1:0] mem_data_a,
  output logic                  mem_we_a
`ifdef MEM_DMA_CSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] csum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q;
  state_t                state_d;
  logic                  accept;
  logic                  active;
  logic                  abort_act;
  logic                  abort_q;
  logic                  rd_pend;
  logic                  capture;
  logic                  wr_last_q;
  dir_t                  cmd_dir;
  logic [ADDR_WIDTH-1:0] rd_start;
  logic [ADDR_WIDTH-1:0] wr_start;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_last;
  logic                  rd_step;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_last;

  // Command handshake, direction choice and start-address computation.
  always_comb begin
    accept    = cmd_valid && cmd_ready;
    active    = (state_q == RUN) || (state_q == DRAIN);
    abort_act = abort && active;
    cmd_dir   = (cmd_dst > cmd_src) ? BWD : FWD;
    // Backward copies begin at the top element of each region.
    rd_start  = (cmd_dir == BWD) ? (cmd_src + cmd_len - ONE) : cmd_src;
    wr_start  = (cmd_dir == BWD) ? (cmd_dst + cmd_len - ONE) : cmd_dst;
    rd_step   = (state_q == RUN) && !abort_act;
    // Data returned by memory this cycle is turned into a write unless aborted.
    capture   = rd_pend && !abort_act;
  end

  mem_dma_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd_gen (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .start(rd_start),
    .dir  (cmd_dir),
    .count(cmd_len),
    .step (rd_step),
    .addr (rd_addr),
    .last (rd_last)
  );

  mem_dma_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .start(wr_start),
    .dir  (cmd_dir),
    .count(cmd_len),
    .step (capture),
    .addr (wr_addr),
    .last (wr_last)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort in RUN/DRAIN goes straight to FIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (cmd_len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = FIN;
        end else if (rd_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = FIN;
        end else if (mem_we_a && wr_last_q) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded from state; FIN reports done or aborted.
  always_comb begin
    cmd_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    done       = (state_q == FIN) && !abort_q;
    aborted    = (state_q == FIN) && abort_q;
    mem_addr_b = rd_addr;
    mem_we_b   = 1'b0;
    mem_data_b = '0;
  end

  // Remembers that the current command was cancelled.
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else if (accept) begin
      abort_q <= 1'b0;
    end else if (abort_act) begin
      abort_q <= 1'b1;
    end
  end

  // Marks that memory returns read data in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= (state_q == RUN) && !abort_act;
    end
  end

  // Write port register: registers returned read data with its write address.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_a   <= 1'b0;
      mem_addr_a <= '0;
      mem_data_a <= '0;
      wr_last_q  <= 1'b0;
    end else if (accept) begin
      mem_we_a  <= 1'b0;
      wr_last_q <= 1'b0;
    end else begin
      mem_we_a <= capture;
      if (capture) begin
        mem_addr_a <= wr_addr;
        mem_data_a <= mem_q_b;
        wr_last_q  <= wr_last;
      end
    end
  end

`ifdef MEM_DMA_CSUM_EN
  // Running sum of every word actually written by this command.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (mem_we_a) begin
      csum <= csum + mem_data_a;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dma_copy.sv
// Self-checking bench for mem_dma_copy with a behavioural dual-port memory.
// Expected reads/writes are queued when a command is issued and compared
// as the DUT presents them. Define MEM_DMA_CSUM_EN to also check csum.
module tb_mem_dma_copy;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW-1:0] mem_addr_b;
  logic          mem_we_b;
  logic [DW-1:0] mem_data_b;
  logic [DW-1:0] mem_q_b;
  logic [AW-1:0] mem_addr_a;
  logic [DW-1:0] mem_data_a;
  logic          mem_we_a;
`ifdef MEM_DMA_CSUM_EN
  logic [DW-1:0] csum;
`endif

  always #5 clk = ~clk;

  mem_dma_copy #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .mem_addr_b(mem_addr_b),
    .mem_we_b  (mem_we_b),
    .mem_data_b(mem_data_b),
    .mem_q_b   (mem_q_b),
    .mem_addr_a(mem_addr_a),
    .mem_data_a(mem_data_a),
    .mem_we_a  (mem_we_a)
`ifdef MEM_DMA_CSUM_EN
    ,
    .csum      (csum)
`endif
  );

  // Behavioural memory: registered read on B, write on A, bench preload port.
  logic [DW-1:0] mem [0:65535];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
    if (pre_we) mem[pre_addr] <= pre_data;
    mem_q_b <= mem[mem_addr_b];
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t wq[$];
  ent_t rq[$];
  ent_t vq[$];

  int            errors = 0;
  int            checks = 0;
  int            edges = 0;
  int            acc_edge = 0;
  bit            track = 1'b1;
  int            nwr = 0;
  logic [DW-1:0] exp_csum = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Edge counter; records the edge at which a command is accepted (end of C0).
  always @(posedge clk) begin
    edges++;
    if (cmd_valid && cmd_ready && !rst) acc_edge = edges;
  end

  // Scoreboard monitor: pops expected writes/reads as the DUT presents them.
  always @(negedge clk) begin
    int   k;
    ent_t e;
    k = edges - acc_edge + 1;
    if (track && !rst) begin
      if (mem_we_a) begin
        nwr++;
        if (wq.size() == 0) begin
          check("spurious_write", 64'(mem_we_a), 64'd0);
        end else begin
          e = wq.pop_front();
          check("wr_addr", 64'(mem_addr_a), 64'(e.addr));
          check("wr_data", 64'(mem_data_a), 64'(e.data));
          check("wr_cycle", 64'(k), 64'(e.cyc));
        end
      end
      if (rq.size() > 0 && rq[0].cyc == k) begin
        e = rq.pop_front();
        check("rd_addr", 64'(mem_addr_b), 64'(e.addr));
        check("rd_we_b", 64'(mem_we_b), 64'd0);
      end
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic flush();
    wq.delete();
    rq.delete();
    vq.delete();
  endtask

  // Queues the memmove-ordered expectations, then issues the command.
  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
    bit            bwd;
    logic [AW-1:0] idx;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    ent_t          e;
    bwd      = (d > s);
    exp_csum = '0;
    nwr      = 0;
    for (int j = 0; j < int'(l); j++) begin
      idx    = bwd ? (l - 16'd1 - 16'(j)) : 16'(j);
      ra     = s + idx;
      wa     = d + idx;
      e.cyc  = j + 1;
      e.addr = ra;
      e.data = '0;
      rq.push_back(e);
      e.cyc  = j + 3;
      e.addr = wa;
      e.data = mem[ra];
      wq.push_back(e);
      vq.push_back(e);
      exp_csum = exp_csum + e.data;
    end
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("accepted", 64'(acc_edge), 64'(edges));
  endtask

  // Waits (bounded) for normal completion and checks timing and memory.
  task automatic wait_end(input int l);
    int dn = 0;
    int ab = 0;
    int dk = 0;
    int ek = 0;
    for (int c = 0; c < l + 40; c++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        dk = edges - acc_edge + 1;
`ifdef MEM_DMA_CSUM_EN
        check("csum", 64'(csum), 64'(exp_csum));
`endif
      end
      if (aborted) ab++;
      if ((dn + ab) > 0 && !busy) begin
        ek = edges - acc_edge + 1;
        break;
      end
    end
    check("done_count", 64'(dn), 64'd1);
    check("aborted_count", 64'(ab), 64'd0);
    check("done_cycle", 64'(dk), (l == 0) ? 64'd1 : 64'(l + 3));
    check("idle_cycle", 64'(ek), (l == 0) ? 64'd2 : 64'(l + 4));
    check("ready_after", 64'(cmd_ready), 64'd1);
    check("writes_left", 64'(wq.size()), 64'd0);
    @(posedge clk);
    #1;
    foreach (vq[i]) check("mem_result", 64'(mem[vq[i].addr]), 64'(vq[i].data));
    flush();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn;
    int ab;
    int late;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_we_a", 64'(mem_we_a), 64'd0);
    check("rst_addr_a", 64'(mem_addr_a), 64'd0);
    check("rst_addr_b", 64'(mem_addr_b), 64'd0);
    check("rst_data_a", 64'(mem_data_a), 64'd0);
    check("rst_we_b", 64'(mem_we_b), 64'd0);
    check("rst_data_b", 64'(mem_data_b), 64'd0);
`ifdef MEM_DMA_CSUM_EN
    check("rst_csum", 64'(csum), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Forward, non-overlapping.
    for (int i = 0; i < 8; i++) poke(16'h4000 + 16'(i), 32'h1000 + 32'(i));
    issue(16'h4000, 16'h5000, 16'd8);
    wait_end(8);

    // Overlap, destination above source: backward copy.
    for (int i = 0; i < 10; i++) poke(16'h6000 + 16'(i), 32'(i));
    issue(16'h6000, 16'h6003, 16'd10);
    wait_end(10);

    // Overlap, destination below source: forward copy.
    for (int i = 0; i < 10; i++) poke(16'h7003 + 16'(i), 32'hA0 + 32'(i));
    issue(16'h7003, 16'h7000, 16'd10);
    wait_end(10);

    // Source wraps through 0xFFFF -> 0x0000.
    poke(16'hFFFE, 32'hCAFE0000);
    poke(16'hFFFF, 32'hCAFE0001);
    poke(16'h0000, 32'hCAFE0002);
    poke(16'h0001, 32'hCAFE0003);
    issue(16'hFFFE, 16'h2000, 16'd4);
    wait_end(4);

    // Zero length.
    issue(16'h0100, 16'h0200, 16'd0);
    wait_end(0);

    // Abort during C6 of a 20-word copy.
    for (int i = 0; i < 20; i++) poke(16'h3000 + 16'(i), 32'h5500 + 32'(i));
    issue(16'h3000, 16'h3100, 16'd20);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    track = 1'b0;
    dn = 0;
    ab = 0;
    late = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) dn++;
      if (aborted) ab++;
      if (mem_we_a) late++;
    end
    check("abort_pulses", 64'(ab), 64'd1);
    check("abort_done", 64'(dn), 64'd0);
    check("abort_late_writes", 64'(late), 64'd0);
    check("abort_writes", 64'(nwr), 64'd4);
    check("abort_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    flush();
    track = 1'b1;

    // Next command after abort; words 1..8 give a checksum of 36.
    for (int i = 0; i < 8; i++) poke(16'h0800 + 16'(i), 32'(i + 1));
    issue(16'h0800, 16'h0900, 16'd8);
    wait_end(8);

    // Reset asserted during C4 of a running copy.
    issue(16'h4000, 16'h5800, 16'd8);
    repeat (3) @(posedge clk);
    #1;
    track = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_we_a", 64'(mem_we_a), 64'd0);
    check("rst_mid_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush();
    track = 1'b1;

    // Engine usable again after reset.
    for (int i = 0; i < 3; i++) poke(16'h0A00 + 16'(i), 32'h77 + 32'(i));
    issue(16'h0A00, 16'h0A10, 16'd3);
    wait_end(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
